// File: rtl/plat_scheduler.sv
// plat_scheduler: per-frame scroll / retire / respawn sequencer for the platform slot table
module plat_scheduler #(
  parameter int          NUM_PLAT  = 15,
  parameter int          FIELD_H   = 480,
  parameter int          X_MAX     = 400,
  parameter int          START_X   = 200,
  parameter int          INIT_GAP  = 32,
  parameter int          PARK_Y    = 511,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic                  game_reset,
  input  logic [7:0]            scroll_amt,
  input  logic [1:0]            difficulty,
  output logic [9*NUM_PLAT-1:0] platX_flat,
  output logic [9*NUM_PLAT-1:0] platY_flat,
  output logic [NUM_PLAT-1:0]   plat_live,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  retired,
  output logic                  overrun
);
  typedef enum logic [2:0] {INIT, IDLE, SCROLL, RECYCLE, DONE} state_t;
  localparam int IW = $clog2(NUM_PLAT);
  localparam logic [IW-1:0] LAST = IW'(NUM_PLAT - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0] fs_q, fs_d;
  logic [7:0] amt_q, amt_d;
  logic [1:0] diff_q, diff_d;
  logic [9:0] min_q, min_d;
  logic [8:0] px_q [NUM_PLAT];
  logic [8:0] px_d [NUM_PLAT];
  logic [8:0] py_q [NUM_PLAT];
  logic [8:0] py_d [NUM_PLAT];
  logic [NUM_PLAT-1:0] live_q, live_d;
  logic busy_q, busy_d, done_q, done_d, ret_q, ret_d, ovr_q, ovr_d;
  logic fedge, last, step;
  logic [8:0] r, rx;
  logic [9:0] s, gap, base;
  logic [10:0] yi;
  assign fedge = fs_q[1] & ~fs_q[2];
  assign last = idx_q == LAST;
  assign step = state_q == INIT || state_q == SCROLL || state_q == RECYCLE;
  assign r = lfsr_q[8:0];
  assign rx = r > 9'(X_MAX) ? r - 9'(X_MAX) - 9'd1 : r;
  assign s = {1'b0, py_q[idx_q]} + {2'b0, amt_q};
  assign gap = diff_q == 2'd0 ? 10'd24 : diff_q == 2'd1 ? 10'd40 : 10'd56;
  assign yi = 11'(FIELD_H - 16) - 11'(idx_q) * 11'(INIT_GAP);
  assign base = idx_q == '0 ? 10'(FIELD_H) : min_q;
  // state, table and pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= INIT;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      fs_q    <= '0;
      amt_q   <= '0;
      diff_q  <= '0;
      min_q   <= 10'(FIELD_H);
      for (int k = 0; k < NUM_PLAT; k++) begin
        px_q[k] <= '0;
        py_q[k] <= 9'(PARK_Y);
      end
      live_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ret_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      fs_q    <= fs_d;
      amt_q   <= amt_d;
      diff_q  <= diff_d;
      min_q   <= min_d;
      px_q    <= px_d;
      py_q    <= py_d;
      live_q  <= live_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ret_q   <= ret_d;
      ovr_q   <= ovr_d;
    end
  end
  // pass sequencing: one slot per cycle through INIT, SCROLL and RECYCLE
  always_comb begin
    idx_d = game_reset || (step && last) ? '0 : step ? idx_q + 1'b1 : idx_q;
    state_d = game_reset ? INIT :
              state_q == INIT && last ? IDLE :
              state_q == IDLE && fedge ? SCROLL :
              state_q == SCROLL && last ? RECYCLE :
              state_q == RECYCLE && last ? DONE :
              state_q == DONE ? IDLE : state_q;
  end
  // slot datapath, frame-edge capture and registered status outputs
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    fs_d = {fs_q[1:0], frame_clk};
    amt_d = amt_q;
    diff_d = diff_q;
    min_d = min_q;
    px_d = px_q;
    py_d = py_q;
    live_d = live_q;
    ret_d = 1'b0;
    done_d = !game_reset && state_q == DONE;
    busy_d = state_d != IDLE;
    ovr_d = !game_reset && (ovr_q || (fedge && state_q != IDLE));
    if (!game_reset) begin
      if (state_q == INIT) begin
        px_d[idx_q] = idx_q == '0 ? 9'(START_X) : rx;
        py_d[idx_q] = yi[10] ? 9'(PARK_Y) : yi[8:0];
        live_d[idx_q] = !yi[10];
        min_d = !yi[10] && yi[9:0] < base ? yi[9:0] : base;
      end else if (state_q == IDLE && fedge) begin
        amt_d = scroll_amt;
        diff_d = difficulty;
        min_d = 10'(FIELD_H);
      end else if (state_q == SCROLL && live_q[idx_q]) begin
        live_d[idx_q] = s < 10'(FIELD_H);
        py_d[idx_q] = s < 10'(FIELD_H) ? s[8:0] : 9'(PARK_Y);
        ret_d = s >= 10'(FIELD_H);
        min_d = s < min_q ? s : min_q;
      end else if (state_q == RECYCLE && !live_q[idx_q] && min_q >= gap) begin
        px_d[idx_q] = rx;
        py_d[idx_q] = '0;
        live_d[idx_q] = 1'b1;
        min_d = '0;
      end
    end
  end
  for (genvar i = 0; i < NUM_PLAT; i++) begin : g_flat
    assign platX_flat[9*i +: 9] = px_q[i];
    assign platY_flat[9*i +: 9] = py_q[i];
  end
  assign plat_live = live_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign retired = ret_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_plat_scheduler.sv
// tb_plat_scheduler: directed checks of init layout, scroll, retire, respawn, overrun and game_reset
module tb_plat_scheduler;
  logic Clk = 0, Reset_n = 0, frame_clk = 0, game_reset = 0;
  logic [7:0] scroll_amt = 0;
  logic [1:0] difficulty = 0;
  logic [134:0] platX_flat, platY_flat;
  logic [14:0] plat_live;
  logic busy, frame_done, retired, overrun;
  int checks = 0, errors = 0;
  int c, rt, nd;

  always #5 Clk = ~Clk;

  plat_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .game_reset(game_reset),
    .scroll_amt(scroll_amt), .difficulty(difficulty),
    .platX_flat(platX_flat), .platY_flat(platY_flat), .plat_live(plat_live),
    .busy(busy), .frame_done(frame_done), .retired(retired), .overrun(overrun)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic int gx(input int i);
    return int'(platX_flat[9*i +: 9]);
  endfunction

  function automatic int gy(input int i);
    return int'(platY_flat[9*i +: 9]);
  endfunction

  task automatic frame(input int amt, input int dif, output int cyc, output int ret);
    scroll_amt = 8'(amt);
    difficulty = 2'(dif);
    frame_clk = 1;
    cyc = 0;
    ret = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
      ret += int'(retired);
    end while (!frame_done && cyc < 200);
    frame_clk = 0;
    tick(1);
    chk("done_one_cycle", int'(frame_done), 0);
    chk("idle_after_done", int'(busy), 0);
    tick(3);
  endtask

  task automatic check_layout(input string tag);
    chk({tag, "_x0"}, gx(0), 200);
    chk({tag, "_y0"}, gy(0), 464);
    chk({tag, "_y7"}, gy(7), 240);
    chk({tag, "_y14"}, gy(14), 16);
    chk({tag, "_live"}, int'(plat_live), 'h7fff);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_busy", int'(busy), 1);
    chk("rst_live", int'(plat_live), 0);
    chk("rst_x0", gx(0), 0);
    chk("rst_y0", gy(0), 511);
    chk("rst_ovr", int'(overrun), 0);
    Reset_n = 1;
    tick(16);
    check_layout("init");
    frame(10, 0, c, rt);
    chk("f1_lat", c, 34);
    chk("f1_ret", rt, 0);
    chk("f1_y0", gy(0), 474);
    chk("f1_y14", gy(14), 26);
    chk("f1_x0", gx(0), 200);
    frame(8, 0, c, rt);
    chk("f2_lat", c, 34);
    chk("f2_ret", rt, 1);
    chk("f2_y0", gy(0), 0);
    chk("f2_live0", int'(plat_live[0]), 1);
    chk("f2_x0_range", int'(gx(0) <= 400), 1);
    chk("f2_y1", gy(1), 450);
    frame(30, 2, c, rt);
    chk("f3_lat", c, 34);
    chk("f3_ret", rt, 1);
    chk("f3_live1", int'(plat_live[1]), 0);
    chk("f3_y1", gy(1), 511);
    chk("f3_y0", gy(0), 30);
    chk("f3_y14", gy(14), 64);
    scroll_amt = 5;
    difficulty = 0;
    frame_clk = 1;
    tick(10);
    frame_clk = 0;
    tick(4);
    frame_clk = 1;
    c = 14;
    do begin
      tick(1);
      c++;
    end while (!frame_done && c < 200);
    chk("ov_lat", c, 34);
    tick(3);
    chk("ov_busy", int'(busy), 0);
    chk("ov_flag", int'(overrun), 1);
    chk("ov_y0", gy(0), 35);
    chk("ov_y14", gy(14), 69);
    chk("ov_y1", gy(1), 0);
    chk("ov_live1", int'(plat_live[1]), 1);
    frame_clk = 0;
    tick(3);
    game_reset = 1;
    tick(1);
    game_reset = 0;
    chk("gr_ovr", int'(overrun), 0);
    chk("gr_busy", int'(busy), 1);
    tick(16);
    check_layout("gr");
    frame(15, 0, c, rt);
    chk("b479_y0", gy(0), 479);
    chk("b479_live0", int'(plat_live[0]), 1);
    chk("b479_ret", rt, 0);
    frame(0, 0, c, rt);
    chk("z_y0", gy(0), 479);
    chk("z_y14", gy(14), 31);
    chk("z_ret", rt, 0);
    frame(1, 0, c, rt);
    chk("b480_ret", rt, 1);
    chk("b480_y0", gy(0), 0);
    chk("b480_live0", int'(plat_live[0]), 1);
    chk("b480_y14", gy(14), 32);
    scroll_amt = 3;
    frame_clk = 1;
    tick(24);
    game_reset = 1;
    tick(1);
    game_reset = 0;
    frame_clk = 0;
    chk("mr_busy", int'(busy), 1);
    chk("mr_done", int'(frame_done), 0);
    nd = 0;
    repeat (20) begin
      tick(1);
      nd += int'(frame_done);
    end
    chk("mr_nodone", nd, 0);
    check_layout("mr");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
